fsb_master: RTL and testbench
=============================

// Module: fsb_master
// PURPOSE
// - Initiator end of the MC68HC000-style front-side bus: turns an internal one-word request into a full AS/UDS/LDS/RW bus cycle.
// - Terminates on nDTACK, or on nVPA for a 6800-style synchronous cycle on E.
// - Raises an internal bus error on timeout. Feeds the responder logic that drives nDTACK/nVPA.
// PARAMETERS
// - TIMEOUT_CYC  64  FCLK cycles in WAIT with no termination before bus error (>=2)
// - ECLK_DIV     10  E period in FCLK cycles; E low for counts 0..5, high for 6..9 (fixed 6/4 split, ECLK_DIV must be 10)
// PORTS
// - FCLK      in   1   bus clock, all logic on posedge
// - RST       in   1   asynchronous reset, active-high
// - Req       in   1   request; sampled only in IDLE
// - ReqWr     in   1   1 = write, 0 = read
// - ReqAddr   in   23  word address A[23:1]
// - ReqWData  in   16  write data
// - ReqBE     in   2   byte enables {upper, lower}; 2'b00 is treated as 2'b11
// - Busy      out  1   high from cycle after Req accepted until IDLE
// - Ack       out  1   one-cycle completion pulse
// - RspErr    out  1   valid with Ack; 1 = timeout
// - RspData   out  16  read data, valid with Ack, held until next Ack
// - A         out  23  bus address, latched at accept
// - Dout      out  16  bus write data;  Doe out 1 output enable for Dout
// - Din       in   16  bus read data
// - nAS, nUDS, nLDS, nRW, nVMA  out  1  bus strobes, active-low
// - E         out  1   6800 enable clock, free-running
// - nDTACK, nVPA  in  1  termination inputs, sampled raw on posedge (responder registers them on FCLK)
// BEHAVIOUR
// Reset (async)
// - nAS, nUDS, nLDS, nRW, nVMA = 1; Doe = 0; Busy, Ack, RspErr = 0; RspData = 0; A = 0.
// - State -> IDLE; E counter = 0, so E = 0.
// - Reset mid-cycle releases all strobes immediately; no Ack is produced.
// E generator
// - Counter ecnt runs 0..9 and wraps; E = (ecnt >= 6). Unaffected by bus state.
// States (one FCLK per state unless noted)
// - IDLE: Req=1 latches address/data/Wr/BE -> S1.
// - S1: A valid; nRW = !Wr; Doe = Wr. All strobes still high.
// - S2: nAS = 0. Read: nUDS/nLDS = !BE this cycle, -> WAIT. Write: -> S3.
// - S3 (write only): nUDS/nLDS = !BE -> WAIT.
// - WAIT: tcnt increments per cycle, cleared on entry.
//   - nDTACK = 0 -> DATA (DTACK wins if nVPA also low).
//   - else nVPA = 0 -> VSYNC.
//   - else tcnt == TIMEOUT_CYC-1 -> ERR.
// - DATA: read latches Din -> RspData; -> END.
// - VSYNC: wait until ecnt == 0, then nVMA = 0 -> VCYC.
//   - VSYNC/VCYC have no timeout; they are bounded by E (<= 2*ECLK_DIV).
// - VCYC: hold until ecnt == 9 (last E-high cycle); latch Din on reads -> END.
// - ERR: RspErr = 1, RspData = 16'hFFFF on reads (unchanged on writes) -> END.
// - END: nAS, nUDS, nLDS, nVMA = 1; Ack = 1 for this cycle only; Doe stays high this cycle (write data hold).
//   Then -> IDLE with nRW = 1, Doe = 0.
// Latency and handshake
// - Minimum read: Req in cycle 0, nAS low cycles 2-4, Ack in cycle 5. Minimum write: Ack in cycle 6.
// - nAS is high for >= 2 cycles between bus cycles (END + IDLE); a held Req restarts from IDLE.
// - Req while Busy is ignored; Req is not queued.
// TESTING
// - Read, nDTACK low from reset:
//   ReqAddr=23'h000100, BE=11 -> nAS low cycles 2-4, nUDS/nLDS low cycle 2, Ack cycle 5, RspData=Din=16'h1234, RspErr=0.
// - Write, BE=01, nDTACK held high 3 WAIT cycles:
//   nUDS stays high, nLDS low from S3, Doe high S1..END, Ack once, Dout=ReqWData.
// - VPA read issued at ecnt=3:
//   nVMA falls at ecnt=0, Din latched at ecnt=9, Ack the next cycle; E is 6 low / 4 high throughout.
// - No termination:
//   Ack with RspErr=1 after exactly TIMEOUT_CYC WAIT cycles; read RspData=16'hFFFF; strobes high the cycle after Ack.
// - nDTACK and nVPA low together -> DTACK path taken, nVMA never asserts.
// - RST pulse during WAIT:
//   strobes high and Doe=0 immediately, no Ack; Req re-issued after reset completes normally.

Source files
------------

// File: rtl/fsb_master.sv
// Front-side bus initiator: converts a one-word internal request into an AS/UDS/LDS/RW
// bus cycle terminated by nDTACK, by a 6800-style nVPA/E cycle, or by a bus-error timeout.
module fsb_master #(
  parameter int TIMEOUT_CYC = 64,
  parameter int ECLK_DIV    = 10
) (
  input  logic        FCLK,
  input  logic        RST,
  input  logic        Req,
  input  logic        ReqWr,
  input  logic [22:0] ReqAddr,
  input  logic [15:0] ReqWData,
  input  logic [1:0]  ReqBE,
  output logic        Busy,
  output logic        Ack,
  output logic        RspErr,
  output logic [15:0] RspData,
  output logic [22:0] A,
  output logic [15:0] Dout,
  output logic        Doe,
  input  logic [15:0] Din,
  output logic        nAS,
  output logic        nUDS,
  output logic        nLDS,
  output logic        nRW,
  output logic        nVMA,
  output logic        E,
  input  logic        nDTACK,
  input  logic        nVPA
);
  localparam int TCW = (TIMEOUT_CYC > 2) ? $clog2(TIMEOUT_CYC) : 1;

  typedef enum logic [3:0] {
    ST_IDLE, ST_S1, ST_S2, ST_S3, ST_WAIT, ST_DATA, ST_VSYNC, ST_VCYC, ST_ERR, ST_END
  } state_t;

  state_t         state, nxt;
  logic [3:0]     ecnt;
  logic [TCW-1:0] tcnt;
  logic           wr_q;
  logic [1:0]     be_q;
  logic           e_last;
  logic           strb_on;
  logic           in_cyc;

  assign e_last = (ecnt == 4'(ECLK_DIV - 1));

  // E runs freely; the bus FSM only observes it
  always_ff @(posedge FCLK or posedge RST) begin
    if (RST)         ecnt <= '0;
    else if (e_last) ecnt <= '0;
    else             ecnt <= ecnt + 4'd1;
  end

  always_ff @(posedge FCLK or posedge RST) begin
    if (RST) state <= ST_IDLE;
    else     state <= nxt;
  end

  always_comb begin
    nxt = state;
    case (state)
      ST_IDLE:  if (Req) nxt = ST_S1;
      ST_S1:    nxt = ST_S2;
      ST_S2:    nxt = wr_q ? ST_S3 : ST_WAIT;
      ST_S3:    nxt = ST_WAIT;
      ST_WAIT: begin
        if (!nDTACK)                           nxt = ST_DATA;
        else if (!nVPA)                        nxt = ST_VSYNC;
        else if (tcnt == TCW'(TIMEOUT_CYC-1))  nxt = ST_ERR;
      end
      ST_DATA:  nxt = ST_END;
      ST_VSYNC: if (ecnt == 4'd0) nxt = ST_VCYC;
      ST_VCYC:  if (e_last) nxt = ST_END;
      ST_ERR:   nxt = ST_END;
      ST_END:   nxt = ST_IDLE;
      default:  nxt = ST_IDLE;
    endcase
  end

  always_ff @(posedge FCLK or posedge RST) begin
    if (RST) begin
      A       <= '0;
      Dout    <= '0;
      wr_q    <= 1'b0;
      be_q    <= 2'b11;
      tcnt    <= '0;
      RspData <= '0;
      RspErr  <= 1'b0;
    end else begin
      if (state == ST_IDLE && Req) begin
        A    <= ReqAddr;
        Dout <= ReqWData;
        wr_q <= ReqWr;
        be_q <= (ReqBE == 2'b00) ? 2'b11 : ReqBE;
      end
      tcnt <= (state == ST_WAIT) ? tcnt + TCW'(1) : '0;
      if (state == ST_DATA || (state == ST_VCYC && e_last)) begin
        RspErr <= 1'b0;
        if (!wr_q) RspData <= Din;
      end else if (state == ST_ERR) begin
        RspErr <= 1'b1;
        if (!wr_q) RspData <= 16'hFFFF;
      end
    end
  end

  // Strobes decode straight from state so an async reset releases them at once
  always_comb begin
    in_cyc  = (state != ST_IDLE);
    strb_on = 1'b0;
    nAS     = 1'b1;
    case (state)
      ST_S2:                                       begin nAS = 1'b0; strb_on = !wr_q; end
      ST_S3, ST_WAIT, ST_DATA, ST_VSYNC, ST_VCYC,
      ST_ERR:                                      begin nAS = 1'b0; strb_on = 1'b1; end
      default:                                     ;
    endcase
    nUDS = !(strb_on && be_q[1]);
    nLDS = !(strb_on && be_q[0]);
    nRW  = !(in_cyc && wr_q);
    Doe  = in_cyc && wr_q;
    Busy = in_cyc;
    Ack  = (state == ST_END);
    nVMA = !((state == ST_VCYC) || (state == ST_VSYNC && ecnt == 4'd0));
    E    = (ecnt >= 4'd6);
  end
endmodule

// File: tb/tb_fsb_master.sv
// Directed bench for fsb_master: table of DTACK/timeout transactions plus
// hand sequences for reset-in-WAIT and the VPA/E cycle.
module tb_fsb_master;
  logic        FCLK = 1'b0;
  logic        RST = 1'b1;
  logic        Req = 1'b0, ReqWr = 1'b0;
  logic [22:0] ReqAddr = '0;
  logic [15:0] ReqWData = '0, Din = '0;
  logic [1:0]  ReqBE = 2'b11;
  logic        nDTACK = 1'b1, nVPA = 1'b1;
  logic        Busy, Ack, RspErr, Doe, nAS, nUDS, nLDS, nRW, nVMA, E;
  logic [15:0] RspData, Dout;
  logic [22:0] A;

  int checks = 0;
  int errors = 0;

  fsb_master dut (
    .FCLK(FCLK), .RST(RST), .Req(Req), .ReqWr(ReqWr), .ReqAddr(ReqAddr),
    .ReqWData(ReqWData), .ReqBE(ReqBE), .Busy(Busy), .Ack(Ack), .RspErr(RspErr),
    .RspData(RspData), .A(A), .Dout(Dout), .Doe(Doe), .Din(Din), .nAS(nAS),
    .nUDS(nUDS), .nLDS(nLDS), .nRW(nRW), .nVMA(nVMA), .E(E),
    .nDTACK(nDTACK), .nVPA(nVPA)
  );

  always #5 FCLK = ~FCLK;

  typedef struct {
    bit          wr;
    logic [22:0] addr;
    logic [15:0] wdata;
    logic [1:0]  be;
    logic [15:0] din;
    int          dtack_cyc;  // first cycle (from Req) with nDTACK low
    bit          vpa;        // hold nVPA low throughout
    int          lat;        // expected Ack cycle
    bit          uds, lds;   // expected strobe levels while active
    logic [15:0] rdata;
    bit          err;
  } vec_t;

  vec_t vt[9];

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  // Entered and left at #1 into an IDLE cycle
  task automatic run_txn(input vec_t v, input int idx);
    int ack_at;
    logic p_uds, p_lds, p_as;
    ack_at = -1;
    p_uds = 1'b1; p_lds = 1'b1; p_as = 1'b1;
    ReqWr = v.wr; ReqAddr = v.addr; ReqWData = v.wdata; ReqBE = v.be;
    Din = v.din; nVPA = !v.vpa; Req = 1'b1;
    for (int c = 0; c < 120; c++) begin
      if (ack_at >= 0) begin
        chk($sformatf("v%0d idle nAS", idx), nAS, 1'b1);
        chk($sformatf("v%0d idle Busy", idx), Busy, 1'b0);
        chk($sformatf("v%0d idle Doe", idx), Doe, 1'b0);
        chk($sformatf("v%0d idle nRW", idx), nRW, 1'b1);
        chk($sformatf("v%0d single Ack", idx), Ack, 1'b0);
        break;
      end
      nDTACK = (c >= v.dtack_cyc) ? 1'b0 : 1'b1;
      if (c == 1) begin
        chk($sformatf("v%0d A", idx), A, v.addr);
        chk($sformatf("v%0d S1 nRW", idx), nRW, !v.wr);
        chk($sformatf("v%0d S1 Doe", idx), Doe, v.wr);
        chk($sformatf("v%0d S1 Busy", idx), Busy, 1'b1);
        chk($sformatf("v%0d S1 nAS", idx), nAS, 1'b1);
      end
      if (nVMA !== 1'b1) chk($sformatf("v%0d nVMA c%0d", idx, c), nVMA, 1'b1);
      if (Ack === 1'b1) begin
        ack_at = c;
        chk($sformatf("v%0d Ack cycle", idx), c, v.lat);
        chk($sformatf("v%0d RspErr", idx), RspErr, v.err);
        chk($sformatf("v%0d RspData", idx), RspData, v.rdata);
        chk($sformatf("v%0d END nAS", idx), nAS, 1'b1);
        chk($sformatf("v%0d END Doe", idx), Doe, v.wr);
        chk($sformatf("v%0d pre-END nAS", idx), p_as, 1'b0);
        chk($sformatf("v%0d nUDS", idx), p_uds, v.uds);
        chk($sformatf("v%0d nLDS", idx), p_lds, v.lds);
        if (v.wr) chk($sformatf("v%0d Dout", idx), Dout, v.wdata);
      end
      p_uds = nUDS; p_lds = nLDS; p_as = nAS;
      @(posedge FCLK); #1;
      Req = 1'b0;
    end
    if (ack_at < 0) chk($sformatf("v%0d Ack timeout", idx), 32'd0, 32'd1);
    nVPA = 1'b1;
  endtask

  // Leaves the bench #1 after the first edge with RST low: that cycle has ecnt=0
  task automatic do_reset(input string tag);
    RST = 1'b1; Req = 1'b0; nDTACK = 1'b1; nVPA = 1'b1;
    @(posedge FCLK); #1;
    chk({tag, " nAS"}, nAS, 1'b1);
    chk({tag, " nUDS/nLDS"}, {nUDS, nLDS}, 2'b11);
    chk({tag, " nRW/nVMA"}, {nRW, nVMA}, 2'b11);
    chk({tag, " Doe/Busy/Ack/Err"}, {Doe, Busy, Ack, RspErr}, 4'b0000);
    chk({tag, " RspData"}, RspData, 16'h0000);
    chk({tag, " A"}, A, 23'h0);
    chk({tag, " E"}, E, 1'b0);
    @(posedge FCLK); #1;
    RST = 1'b0;
  endtask

  initial begin
    vt[0] = '{1'b0, 23'h000100, 16'h0000, 2'b11, 16'h1234,    0, 1'b0,  5, 1'b0, 1'b0, 16'h1234, 1'b0};
    vt[1] = '{1'b1, 23'h0ABCDE, 16'hBEEF, 2'b01, 16'h0000,    7, 1'b0,  9, 1'b1, 1'b0, 16'h1234, 1'b0};
    vt[2] = '{1'b0, 23'h7FFFFF, 16'h0000, 2'b10, 16'h5A5A,    5, 1'b0,  7, 1'b0, 1'b1, 16'h5A5A, 1'b0};
    vt[3] = '{1'b0, 23'h000002, 16'h0000, 2'b00, 16'h0F0F,    3, 1'b0,  5, 1'b0, 1'b0, 16'h0F0F, 1'b0};
    vt[4] = '{1'b1, 23'h123456, 16'hA55A, 2'b11, 16'h0000,    0, 1'b0,  6, 1'b0, 1'b0, 16'h0F0F, 1'b0};
    vt[5] = '{1'b0, 23'h000010, 16'h0000, 2'b11, 16'h9999,    0, 1'b1,  5, 1'b0, 1'b0, 16'h9999, 1'b0};
    vt[6] = '{1'b0, 23'h000020, 16'h0000, 2'b11, 16'h2222, 1000, 1'b0, 68, 1'b0, 1'b0, 16'hFFFF, 1'b1};
    vt[7] = '{1'b0, 23'h000030, 16'h0000, 2'b11, 16'h1357,    0, 1'b0,  5, 1'b0, 1'b0, 16'h1357, 1'b0};
    vt[8] = '{1'b1, 23'h000040, 16'h0001, 2'b10, 16'h0000, 1000, 1'b0, 69, 1'b0, 1'b1, 16'h1357, 1'b1};

    do_reset("reset");
    for (int i = 0; i < 9; i++) run_txn(vt[i], i);

    // Reset pulse while a write sits in WAIT
    ReqWr = 1'b1; ReqAddr = 23'h000555; ReqWData = 16'h7777; ReqBE = 2'b11;
    nDTACK = 1'b1; nVPA = 1'b1; Req = 1'b1;
    for (int k = 0; k < 6; k++) begin
      @(posedge FCLK); #1;
      Req = 1'b0;
    end
    chk("rstwait pre Doe", Doe, 1'b1);
    chk("rstwait pre nAS", nAS, 1'b0);
    #1 RST = 1'b1;
    #1;
    chk("rstwait strobes", {nAS, nUDS, nLDS, nRW, nVMA}, 5'b11111);
    chk("rstwait Doe/Busy/Ack", {Doe, Busy, Ack}, 3'b000);
    for (int k = 0; k < 3; k++) begin
      @(posedge FCLK); #1;
      chk("rstwait no Ack", Ack, 1'b0);
    end
    RST = 1'b0;
    run_txn(vt[0], 100);

    // VPA read requested in the ecnt=3 cycle after a fresh reset
    do_reset("reset2");
    ReqWr = 1'b0; ReqAddr = 23'h000200; ReqBE = 2'b11; nDTACK = 1'b1; nVPA = 1'b0;
    for (int m = 0; m < 25; m++) begin
      Req = (m == 3);
      Din = (m == 19) ? 16'hC0DE : 16'hDEAD;
      chk($sformatf("vpa E m%0d", m), E, ((m % 10) >= 6));
      chk($sformatf("vpa nVMA m%0d", m), nVMA, !(m >= 10 && m <= 19));
      chk($sformatf("vpa Ack m%0d", m), Ack, (m == 20));
      if (m == 20) begin
        chk("vpa RspData", RspData, 16'hC0DE);
        chk("vpa RspErr", RspErr, 1'b0);
      end
      if (m >= 5 && m <= 19) chk($sformatf("vpa nAS m%0d", m), nAS, 1'b0);
      @(posedge FCLK); #1;
    end
    Req = 1'b0; nVPA = 1'b1;

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
